mem_wb_queue: RTL
=================

MEM_WB_QUEUE -- requirements
Module: mem_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter DATA_WIDTH, default 32, write-back data width.
REQ-003 Parameter PREG_WIDTH, default 6, physical register address width.
REQ-004 Parameter FLOW_THROUGH, default 1; 1 = empty queue passes input to output in the same cycle, 0 = always registered.
REQ-005 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port i_valid, input, 1, mem stage holds an instruction.
REQ-008 Port i_is_mem_access, input, 1, instruction is a load or store.
REQ-009 Port i_cache_valid, input, 1, D-cache result available.
REQ-010 Port i_cache_data, input, DATA_WIDTH, D-cache read data.
REQ-011 Port i_alu_result, input, DATA_WIDTH, ALU result.
REQ-012 Port i_uses_rw, input, 1, instruction writes a register.
REQ-013 Port i_rw_addr, input, PREG_WIDTH, destination physical register.
REQ-014 Port o_done, output, 1, mem stage may advance this cycle.
REQ-015 Port o_wb_valid, output, 1, write-back entry presented.
REQ-016 Port o_wb_addr, output, PREG_WIDTH, write-back physical register.
REQ-017 Port o_wb_data, output, DATA_WIDTH, write-back data.
REQ-018 Port i_wb_ready, input, 1, register file accepts the entry this cycle.
REQ-019 Port i_lookup_addr, input, PREG_WIDTH, forwarding query address.
REQ-020 Port o_lookup_hit, output, 1, a queued entry matches i_lookup_addr.
REQ-021 Port o_lookup_data, output, DATA_WIDTH, data of the youngest matching entry.
REQ-022 Port o_count, output, $clog2(DEPTH)+1, occupancy.

Function
REQ-023 Result ready: rdy = i_valid & (~i_is_mem_access | i_cache_valid).
REQ-024 Enqueue data: i_cache_data if i_is_mem_access, else i_alu_result.
REQ-025 Dequeue: deq = o_wb_valid & i_wb_ready.
REQ-026 Space: count < DEPTH, or count == DEPTH & deq (same-cycle free allowed).
REQ-027 o_done = rdy & (~i_uses_rw | space); combinational.
REQ-028 Push: o_done & i_uses_rw & ~bypass; stores the entry at the tail pointer.
REQ-029 Bypass: FLOW_THROUGH=1 & count==0 & rdy & i_uses_rw & i_wb_ready; the entry is presented on o_wb_* that cycle and never stored.
REQ-030 With count==0, FLOW_THROUGH=1 and rdy & i_uses_rw, o_wb_valid=1 and o_wb_* show the input regardless of i_wb_ready; the entry is stored if not bypassed.
REQ-031 With count>0, o_wb_* show the head entry; strict FIFO order.
REQ-032 FLOW_THROUGH=0: minimum latency of 1 cycle from push to o_wb_valid.
REQ-033 Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
REQ-034 Full (count==DEPTH) without deq: o_done=0 for register-writing instructions; non-writing instructions complete with o_done=rdy.
REQ-035 Lookup: searches stored entries only; youngest match wins; no match gives hit=0, data=0.
REQ-036 Lookup: a match on physical register 0 reports hit=0.
REQ-037 o_count reflects registered occupancy only.
REQ-038 o_wb_data and o_wb_addr are 0 whenever o_wb_valid=0.

Reset
REQ-039 rst_n low asynchronously clears head, tail and count, and forces o_wb_valid=0, o_count=0 and o_lookup_hit=0.
REQ-040 o_done=0 while rst_n is low.
REQ-041 Entry storage is not reset.
REQ-042 Reset mid-operation discards all queued entries.
REQ-043 First operation permitted on the first rising clk edge after rst_n rises.

Verification
REQ-044 FLOW_THROUGH=1, empty, ALU op (addr 5, result 0x1234), ready=1 -> same cycle: o_done=1, o_wb_valid=1, addr 5, data 0x1234; o_count stays 0.
REQ-045 Load with i_cache_valid=0 for 3 cycles, then 1 with data 0xBEEF -> o_done=0 for 3 cycles, then 1; o_wb_data=0xBEEF.
REQ-046 ready=0; push 4 writes (addrs 1-4) -> o_count=4; 5th write sees o_done=0; raise ready -> 5th accepted same cycle, outputs drain 1,2,3,4,5 in order.
REQ-047 Queue holds addr 7 twice (0x1 older, 0x2 younger); lookup 7 -> hit=1, data=0x2; lookup 9 -> hit=0.
REQ-048 Store with uses_rw=0 while full -> o_done=1 once i_cache_valid=1; count unchanged.
REQ-049 Assert rst_n=0 asynchronously with count=3 -> o_wb_valid=0 and o_count=0 before the next clk edge.

Source files
------------

// File: rtl/mem_wb_queue.sv
// Purpose: buffers mem-stage results for register write-back, with forwarding lookup over queued entries.
// Latency: 0 cycles through an empty queue when FLOW_THROUGH=1, otherwise 1 cycle from push to o_wb_valid.
// Backpressure: o_done drops for register-writing instructions when the queue is full and the head is not leaving.
module mem_wb_queue #(
  parameter int DEPTH        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int PREG_WIDTH   = 6,
  parameter int FLOW_THROUGH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic                       i_is_mem_access,
  input  logic                       i_cache_valid,
  input  logic [DATA_WIDTH-1:0]      i_cache_data,
  input  logic [DATA_WIDTH-1:0]      i_alu_result,
  input  logic                       i_uses_rw,
  input  logic [PREG_WIDTH-1:0]      i_rw_addr,
  output logic                       o_done,
  output logic                       o_wb_valid,
  output logic [PREG_WIDTH-1:0]      o_wb_addr,
  output logic [DATA_WIDTH-1:0]      o_wb_data,
  input  logic                       i_wb_ready,
  input  logic [PREG_WIDTH-1:0]      i_lookup_addr,
  output logic                       o_lookup_hit,
  output logic [DATA_WIDTH-1:0]      o_lookup_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit FT = (FLOW_THROUGH != 0);

  // Entry storage; contents are only meaningful between head and tail.
  logic [PREG_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic                  rdy;
  logic [DATA_WIDTH-1:0] enq_data;
  logic                  empty;
  logic                  full;
  logic                  ft_present;
  logic                  deq;
  logic                  space;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  logic                  lk_match;
  logic [DATA_WIDTH-1:0] lk_match_data;
  logic [AW-1:0]         lk_slot;

  // Result availability: non-memory ops are ready at once, memory ops wait for the cache.
  assign rdy      = i_valid & (~i_is_mem_access | i_cache_valid);
  assign enq_data = i_is_mem_access ? i_cache_data : i_alu_result;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // An empty queue can present the incoming result directly on the write-back port.
  assign ft_present = FT & empty & rdy & i_uses_rw;

  // Drive the write-back port: head entry when stored data exists, else the flow-through input.
  always_comb begin
    o_wb_valid = 1'b0;
    o_wb_addr  = '0;
    o_wb_data  = '0;
    if (rst_n) begin
      if (!empty) begin
        o_wb_valid = 1'b1;
        o_wb_addr  = addr_mem[head];
        o_wb_data  = data_mem[head];
      end else if (ft_present) begin
        o_wb_valid = 1'b1;
        o_wb_addr  = i_rw_addr;
        o_wb_data  = enq_data;
      end
    end
  end

  assign deq = o_wb_valid & i_wb_ready;

  // A full queue still accepts when its head drains in the same cycle.
  assign space = ~full | deq;

  assign o_done = rst_n & rdy & (~i_uses_rw | space);

  // A flow-through entry consumed immediately never occupies a slot.
  assign bypass = ft_present & i_wb_ready;
  assign push   = o_done & i_uses_rw & ~bypass;
  assign pop    = deq & ~empty;

  // Store the pushed entry at the tail slot; storage itself is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= i_rw_addr;
      data_mem[tail] <= enq_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Forwarding search from oldest to youngest so the youngest match overrides older ones.
  always_comb begin
    lk_match      = 1'b0;
    lk_match_data = '0;
    lk_slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_slot = head + AW'(i);
      if ((CW'(i) < count) && (addr_mem[lk_slot] == i_lookup_addr)) begin
        lk_match      = 1'b1;
        lk_match_data = data_mem[lk_slot];
      end
    end
  end

  // Register 0 is never forwarded; a miss reports zero data.
  always_comb begin
    o_lookup_hit  = 1'b0;
    o_lookup_data = '0;
    if (lk_match && (i_lookup_addr != '0)) begin
      o_lookup_hit  = 1'b1;
      o_lookup_data = lk_match_data;
    end
  end

  assign o_count = count;

endmodule
